// File: rtl/tank_pkg.sv
// Shared types and helpers for the enemy tank AI.
// Direction codes match the player tank's facing encoding.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'b000,
    DIR_DOWN  = 3'b010,
    DIR_LEFT  = 3'b100,
    DIR_RIGHT = 3'b110
  } dir_t;

  typedef enum logic [1:0] {
    ST_SPAWN  = 2'b00,
    ST_TURN   = 2'b01,
    ST_PATROL = 2'b10
  } ai_state_t;

  localparam logic [7:0] KEY_W    = 8'h1a;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_NONE = 8'h00;

  function automatic dir_t rot_cw(input dir_t d);
    dir_t r;
    unique case (d)
      DIR_UP:    r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_DOWN;
      DIR_DOWN:  r = DIR_LEFT;
      default:   r = DIR_UP;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] dir_key(input dir_t d);
    logic [7:0] k;
    unique case (d)
      DIR_UP:    k = KEY_W;
      DIR_DOWN:  k = KEY_S;
      DIR_LEFT:  k = KEY_A;
      DIR_RIGHT: k = KEY_D;
      default:   k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/enemy_tank_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = r_state[15] ^ r_state[13]
              ^ r_state[12] ^ r_state[10];

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_state <= SEED;
    else       r_state <= {r_state[14:0], w_fb};
  end

  assign state = r_state;

endmodule

// File: rtl/enemy_tank_ctrl.sv
// Enemy tank AI: spawn delay, random patrol, turn on blockage,
// and a held fire request when facing the player.
module enemy_tank_ctrl
  import tank_pkg::*;
#(
  parameter int          SPAWN_DELAY   = 60,
  parameter int          RUN_MIN       = 16,
  parameter int          RUN_MASK      = 63,
  parameter int          FIRE_COOLDOWN = 90,
  parameter int          ALIGN_TOL     = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic        fire_ack,
  output logic [15:0] keycode,
  output logic        fire_req,
  output logic [2:0]  dir,
  output logic [1:0]  ai_state
);

  ai_state_t   r_state;
  dir_t        r_dir;
  logic [15:0] r_spawn;
  logic [15:0] r_run;
  logic [15:0] r_cool;
  logic        r_fire;

  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;
  logic [3:0]  w_free;
  dir_t        w_c0, w_c1, w_c2, w_c3;
  dir_t        w_pick;
  logic        w_found;
  logic [15:0] w_run_len;
  logic [15:0] w_run_dec;
  logic [10:0] w_dx, w_dy, w_adx, w_ady;
  logic        w_xin, w_yin;
  logic        w_aligned;
  logic        w_legal;
  logic        w_active;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .state    (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:8];

  // indexed by dir[2:1]: 0 up, 1 down, 2 left, 3 right
  assign w_free = {right, left, down, up};

  always_comb begin
    w_c0    = dir_t'({w_lfsr[1:0], 1'b0});
    w_c1    = rot_cw(w_c0);
    w_c2    = rot_cw(w_c1);
    w_c3    = rot_cw(w_c2);
    w_found = 1'b1;
    w_pick  = w_c0;
    if (w_free[w_c0[2:1]])      w_pick = w_c0;
    else if (w_free[w_c1[2:1]]) w_pick = w_c1;
    else if (w_free[w_c2[2:1]]) w_pick = w_c2;
    else if (w_free[w_c3[2:1]]) w_pick = w_c3;
    else                        w_found = 1'b0;
  end

  assign w_run_len = 16'(RUN_MIN)
                   + {10'd0, w_lfsr[7:2] & 6'(RUN_MASK)};
  assign w_run_dec = (r_run == 16'd0) ? 16'd0 : r_run - 16'd1;

  assign w_dx  = {1'b0, tank_x} - {1'b0, player_x};
  assign w_dy  = {1'b0, tank_y} - {1'b0, player_y};
  assign w_adx = w_dx[10] ? (~w_dx + 11'd1) : w_dx;
  assign w_ady = w_dy[10] ? (~w_dy + 11'd1) : w_dy;
  assign w_xin = (w_adx <= 11'(ALIGN_TOL));
  assign w_yin = (w_ady <= 11'(ALIGN_TOL));

  always_comb begin
    w_aligned = 1'b0;
    unique case (r_dir)
      DIR_UP:    w_aligned = w_xin && (player_y < tank_y);
      DIR_DOWN:  w_aligned = w_xin && (player_y > tank_y);
      DIR_LEFT:  w_aligned = w_yin && (player_x < tank_x);
      DIR_RIGHT: w_aligned = w_yin && (player_x > tank_x);
      default:   w_aligned = 1'b0;
    endcase
  end

  assign w_legal  = (r_state == ST_SPAWN) || (r_state == ST_TURN)
                 || (r_state == ST_PATROL);
  assign w_active = (r_state == ST_TURN) || (r_state == ST_PATROL);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_SPAWN;
      r_spawn <= 16'(SPAWN_DELAY);
      r_dir   <= DIR_DOWN;
      r_cool  <= 16'(FIRE_COOLDOWN);
      r_run   <= 16'd0;
      r_fire  <= 1'b0;
    end else if (!w_legal) begin
      r_state <= ST_SPAWN;
      r_spawn <= 16'(SPAWN_DELAY);
      r_cool  <= 16'(FIRE_COOLDOWN);
      r_run   <= 16'd0;
      r_fire  <= 1'b0;
    end else begin
      // ack wins; a request is never raised on its own ack edge
      if (r_fire && fire_ack) begin
        r_fire <= 1'b0;
        r_cool <= 16'(FIRE_COOLDOWN);
      end else if (enable && w_active) begin
        if (r_cool != 16'd0) r_cool <= r_cool - 16'd1;
        if (r_cool == 16'd0 && w_aligned && !r_fire)
          r_fire <= 1'b1;
      end
      if (enable) begin
        unique case (r_state)
          ST_SPAWN: begin
            if (r_spawn == 16'd0) r_state <= ST_TURN;
            else                  r_spawn <= r_spawn - 16'd1;
          end
          ST_TURN: begin
            if (w_found) begin
              r_dir   <= w_pick;
              r_run   <= w_run_len;
              r_state <= ST_PATROL;
            end
          end
          ST_PATROL: begin
            r_run <= w_run_dec;
            if (w_run_dec == 16'd0 || !w_free[r_dir[2:1]])
              r_state <= ST_TURN;
          end
          default: r_state <= ST_SPAWN;
        endcase
      end
    end
  end

  assign keycode  = {8'h00, (r_state == ST_PATROL && enable)
                            ? dir_key(r_dir) : KEY_NONE};
  assign fire_req = r_fire;
  assign dir      = r_dir;
  assign ai_state = r_state;

endmodule

// File: tb/tb_enemy_tank_ctrl.sv
// Directed bench for enemy_tank_ctrl: spawn, patrol, blockage,
// pause, fire handshake and asynchronous reset.
module tb_enemy_tank_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic        enable;
  logic        up, down, left, right;
  logic [9:0]  tank_x, tank_y, player_x, player_y;
  logic        fire_ack;
  logic [15:0] keycode;
  logic        fire_req;
  logic [2:0]  dir;
  logic [1:0]  ai_state;

  int          n_cmp;
  int          n_bad;
  logic [15:0] m_lfsr;

  enemy_tank_ctrl #(.FIRE_COOLDOWN(4)) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .enable   (enable),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .tank_x   (tank_x),
    .tank_y   (tank_y),
    .player_x (player_x),
    .player_y (player_y),
    .fire_ack (fire_ack),
    .keycode  (keycode),
    .fire_req (fire_req),
    .dir      (dir),
    .ai_state (ai_state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] exp_key(input logic [2:0] d);
    logic [15:0] k;
    case (d)
      3'b000:  k = 16'h001a;
      3'b010:  k = 16'h0016;
      3'b100:  k = 16'h0004;
      3'b110:  k = 16'h0007;
      default: k = 16'h0000;
    endcase
    return k;
  endfunction

  task automatic step();
    @(posedge frame_clk);
    m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic wait_turn(input string nm);
    int k;
    k = 0;
    while (ai_state !== 2'b01 && k < 200) begin
      step();
      k++;
    end
    n_cmp++;
    if (ai_state !== 2'b01) begin
      n_bad++;
      $display("FAIL %s: ai_state %b, required 01", nm, ai_state);
    end
  endtask

  task automatic test_reset();
    int bad;
    logic [2:0]  ed;
    Reset = 1'b1;
    enable = 1'b1;
    {up, down, left, right} = 4'b1111;
    tank_x = 10'd320; tank_y = 10'd240;
    player_x = 10'd600; player_y = 10'd600;
    fire_ack = 1'b0;
    #12;
    n_cmp++;
    if ({keycode, fire_req, dir, ai_state} !== {16'h0, 1'b0, 3'b010, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_vals: key %h fire %b dir %b st %b, required 0000 0 010 00",
               keycode, fire_req, dir, ai_state);
    end
    Reset = 1'b0;
    m_lfsr = 16'hACE1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ai_state !== 2'b00 || keycode !== 16'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL spawn_hold: %0d bad cycles, required 0", bad);
    end
    step();
    n_cmp++;
    if (ai_state !== 2'b01 || keycode !== 16'h0) begin
      n_bad++;
      $display("FAIL spawn_to_turn: st %b key %h, required 01 0000", ai_state, keycode);
    end
    ed = {m_lfsr[1:0], 1'b0};
    step();
    n_cmp++;
    if (ai_state !== 2'b10 || dir !== ed || keycode !== exp_key(ed)) begin
      n_bad++;
      $display("FAIL first_patrol: st %b dir %b key %h, required 10 %b %h",
               ai_state, dir, keycode, ed, exp_key(ed));
    end
  endtask

  task automatic test_patrol_left();
    int n, cnt;
    {up, down, left, right} = 4'b0010;
    wait_turn("left_turn0");
    for (int r = 0; r < 3; r++) begin
      n = 16 + int'(m_lfsr[7:2]);
      step();
      n_cmp++;
      if (dir !== 3'b100 || keycode !== 16'h0004) begin
        n_bad++;
        $display("FAIL left_pick: dir %b key %h, required 100 0004", dir, keycode);
      end
      cnt = 0;
      while (ai_state === 2'b10 && keycode === 16'h0004 && cnt < 100) begin
        cnt++;
        step();
      end
      n_cmp++;
      if (cnt != n) begin
        n_bad++;
        $display("FAIL run_len: %0d cycles, required %0d", cnt, n);
      end
      n_cmp++;
      if (ai_state !== 2'b01 || keycode !== 16'h0) begin
        n_bad++;
        $display("FAIL turn_gap: st %b key %h, required 01 0000", ai_state, keycode);
      end
    end
  endtask

  task automatic test_pause();
    int n, cnt, bad;
    logic found;
    found = 1'b0;
    for (int r = 0; r < 20 && !found; r++) begin
      n = 16 + int'(m_lfsr[7:2]);
      step();
      if (n > 30) begin
        repeat (n - 30) step();
        found = 1'b1;
      end else begin
        repeat (n) step();
      end
    end
    n_cmp++;
    if (!found || ai_state !== 2'b10) begin
      n_bad++;
      $display("FAIL pause_setup: st %b, required 10", ai_state);
    end
    enable = 1'b0;
    #1;
    n_cmp++;
    if (keycode !== 16'h0) begin
      n_bad++;
      $display("FAIL pause_key: key %h, required 0000", keycode);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (keycode !== 16'h0 || ai_state !== 2'b10 || dir !== 3'b100) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL pause_freeze: %0d bad cycles, required 0", bad);
    end
    enable = 1'b1;
    #1;
    cnt = 0;
    while (ai_state === 2'b10 && keycode === 16'h0004 && cnt < 100) begin
      cnt++;
      step();
    end
    n_cmp++;
    if (cnt != 30 || ai_state !== 2'b01) begin
      n_bad++;
      $display("FAIL pause_resume: %0d cycles st %b, required 30 01", cnt, ai_state);
    end
  endtask

  task automatic test_blocked();
    int bad;
    step();
    step();
    step();
    n_cmp++;
    if (ai_state !== 2'b10 || keycode !== 16'h0004) begin
      n_bad++;
      $display("FAIL block_setup: st %b key %h, required 10 0004", ai_state, keycode);
    end
    left = 1'b0;
    step();
    n_cmp++;
    if (ai_state !== 2'b01 || keycode !== 16'h0) begin
      n_bad++;
      $display("FAIL block_turn: st %b key %h, required 01 0000", ai_state, keycode);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ai_state !== 2'b01 || keycode !== 16'h0 || dir !== 3'b100) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL all_blocked: %0d bad cycles, required 0", bad);
    end
    left = 1'b1;
    step();
    n_cmp++;
    if (ai_state !== 2'b10 || keycode !== 16'h0004) begin
      n_bad++;
      $display("FAIL unblock: st %b key %h, required 10 0004", ai_state, keycode);
    end
  endtask

  task automatic test_fire();
    int bad;
    {up, down, left, right} = 4'b1000;
    player_x = 10'd322;
    player_y = 10'd100;
    pulse_reset();
    bad = 0;
    for (int i = 0; i < 62; i++) begin
      step();
      if (fire_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (ai_state !== 2'b10 || keycode !== 16'h001a) begin
      n_bad++;
      $display("FAIL up_patrol: st %b key %h, required 10 001a", ai_state, keycode);
    end
    repeat (3) begin
      step();
      if (fire_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL cooldown_early: %0d early requests, required 0", bad);
    end
    step();
    n_cmp++;
    if (fire_req !== 1'b1) begin
      n_bad++;
      $display("FAIL fire_raise: fire_req %b, required 1", fire_req);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fire_req !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL fire_hold: %0d dropped cycles, required 0", bad);
    end
    fire_ack = 1'b1;
    step();
    fire_ack = 1'b0;
    n_cmp++;
    if (fire_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fire_ack: fire_req %b, required 0", fire_req);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fire_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rearm_cooldown: %0d early requests, required 0", bad);
    end
    step();
    n_cmp++;
    if (fire_req !== 1'b1) begin
      n_bad++;
      $display("FAIL fire_rearm: fire_req %b, required 1", fire_req);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    if (ai_state !== 2'b10) step();
    n_cmp++;
    if (ai_state !== 2'b10 || fire_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup: st %b fire %b, required 10 1", ai_state, fire_req);
    end
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({keycode, fire_req, dir, ai_state} !== {16'h0, 1'b0, 3'b010, 2'b00}) begin
      n_bad++;
      $display("FAIL async_reset: key %h fire %b dir %b st %b, required 0000 0 010 00",
               keycode, fire_req, dir, ai_state);
    end
    Reset = 1'b0;
    m_lfsr = 16'hACE1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ai_state !== 2'b00) bad++;
    end
    step();
    n_cmp++;
    if (bad != 0 || ai_state !== 2'b01) begin
      n_bad++;
      $display("FAIL respawn: %0d bad cycles st %b, required 0 01", bad, ai_state);
    end
  endtask

  task automatic test_no_fire();
    int bad;
    player_x = 10'd340;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fire_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL offline_dx20: %0d requests, required 0", bad);
    end
    player_x = 10'd329;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (fire_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL offline_dx9: %0d requests, required 0", bad);
    end
    player_x = 10'd328;
    step();
    n_cmp++;
    if (fire_req !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_dx8: fire_req %b, required 1", fire_req);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_lfsr = 16'hACE1;
    test_reset();
    test_patrol_left();
    test_pause();
    test_blocked();
    test_fire();
    test_reset_mid();
    test_no_fire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
